btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Input stage between the raw DE2 push-buttons and the clock's control block.
//  Synchronises, debounces and edge-detects N_BTN buttons: adjust, up_btn, down_btn.
//  Emits one-cycle press/release pulses, plus auto-repeat press pulses on held buttons,
//  so a held up/down button keeps stepping the time.
// PARAMETERS
//  N_BTN          4           number of buttons handled
//  ACTIVE_LOW     1           1: raw pin low = pressed (DE2 KEY); 0: high = pressed
//  DB_CYCLES      1_000_000   cycles of stable synced input to accept a change (20 ms @ 50 MHz)
//  RPT_DELAY      25_000_000  cycles from accepted press to first repeat pulse (500 ms)
//  RPT_PERIOD     5_000_000   cycles between subsequent repeat pulses (100 ms)
//  RPT_MASK       4'b0011     bit i = 1: button i may auto-repeat (up/down only)
// PORTS
//  clk          in   1      system clock, 50 MHz
//  rst          in   1      synchronous reset, active-high
//  btn_raw      in   N_BTN  asynchronous raw button pins
//  btn_level    out  N_BTN  debounced state, 1 = pressed
//  btn_press    out  N_BTN  1-cycle pulse: accepted press or auto-repeat tick
//  btn_release  out  N_BTN  1-cycle pulse: accepted release
// BEHAVIOUR
//  - Reset (clk edge with rst=1): all outputs 0. Counters 0. Sync flops and stable state
//    = released (held internally as active-high after polarity normalisation).
//  - Sync: 2-FF synchroniser per bit; polarity normalised after the first flop.
//  - Debounce, per bit: cnt increments on each cycle where synced != stable.
//    Any cycle where synced == stable clears cnt to 0.
//    When cnt reaches DB_CYCLES-1 and synced still differs: stable <= synced, cnt <= 0.
//  - Glitches shorter than DB_CYCLES cycles never change btn_level.
//  - Latency: raw change held steady -> btn_level updates 2+DB_CYCLES cycles later.
//  - btn_press/btn_release are registered. Each asserts in the same cycle btn_level
//    rises/falls, for exactly 1 cycle.
//  - Repeat FSM, per bit with RPT_MASK[i]=1: IDLE -> HOLD on accepted press (rcnt=0).
//    HOLD: after RPT_DELAY cycles, pulse btn_press and go to RPT (rcnt=0).
//    RPT: pulse btn_press every RPT_PERIOD cycles.
//    Accepted release in any state -> IDLE immediately; no further pulses.
//  - Bits with RPT_MASK[i]=0 stay in IDLE.
//  - Counter widths are $clog2(max(DB_CYCLES,RPT_DELAY,RPT_PERIOD)+1). No wrap: counters
//    are cleared on every terminal count.
//  - Bits are fully independent. Simultaneous presses give simultaneous pulses.
//    No priority logic; the control block resolves up+down conflicts.
//  - Reset mid-hold: outputs drop to 0 on that edge. If the button is still held after
//    rst falls, it re-debounces and produces a fresh press pulse after 2+DB_CYCLES cycles.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: repeat FSMs present, behaviour as above.
//  AUTO_REPEAT_EN undefined: repeat FSMs and counters not built. btn_press fires only
//    on accepted presses; RPT_DELAY, RPT_PERIOD and RPT_MASK are ignored.
// TESTING (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, ACTIVE_LOW=1, N_BTN=4)
//  1. rst=1 for 3 cycles, btn_raw=4'hF -> all outputs 0. Still 0 for 20 cycles after release.
//  2. btn_raw[0] low at cycle 0, held -> btn_level[0]=1 and btn_press[0]=1 at cycle 6,
//     for exactly 1 cycle.
//  3. btn_raw[1] low for 3 cycles, then high -> btn_level and btn_press stay 0 throughout.
//  4. AUTO_REPEAT_EN: hold btn_raw[0] 40 cycles -> press pulses at 6,16,19,22,...
//     On release: btn_release[0] at release+6; no pulses after.
//  5. Hold btn_raw[2] (mask 0) for 40 cycles -> exactly one btn_press[2] pulse.
//     Macro undefined, bit 0 held -> also exactly one pulse.
//  6. Bits 0 and 1 held together; rst pulsed at cycle 12 while held -> both outputs clear.
//     Fresh press pulses at rst-fall+6; repeats resume from the new press.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-FF sync, per-bit debounce, registered press/release pulses.
// Optional auto-repeat engine on held buttons, built only when AUTO_REPEAT_EN is defined.
module btn_conditioner #(
  parameter int                N_BTN      = 4,
  parameter bit                ACTIVE_LOW = 1'b1,
  parameter int                DB_CYCLES  = 1_000_000,
  parameter int                RPT_DELAY  = 25_000_000,
  parameter int                RPT_PERIOD = 5_000_000,
  parameter logic [N_BTN-1:0]  RPT_MASK   = N_BTN'(4'b0011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int MAX_A = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_C = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0]    DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [N_BTN-1:0] RAW_IDLE = ACTIVE_LOW ? '1 : '0;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [CW-1:0]    db_cnt_q [N_BTN];
  logic [CW-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0] rpt_pulse;

  // sync2 holds the polarity-normalised value: 1 = pressed
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = ACTIVE_LOW ? ~sync1_q : sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
    press_d   = (stable_d & ~stable_q) | rpt_pulse;
    release_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_RUN} rpt_state_e;

  localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 1);

  rpt_state_e    rpt_state_q [N_BTN];
  rpt_state_e    rpt_state_d [N_BTN];
  logic [CW-1:0] rpt_cnt_q   [N_BTN];
  logic [CW-1:0] rpt_cnt_d   [N_BTN];

  // Acceptance of a release wins over a repeat tick landing on the same cycle
  always_comb begin
    rpt_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      if (RPT_MASK[i]) begin
        case (rpt_state_q[i])
          RPT_IDLE: begin
            if (stable_d[i] && !stable_q[i]) begin
              rpt_state_d[i] = RPT_HOLD;
              rpt_cnt_d[i]   = '0;
            end
          end
          RPT_HOLD, RPT_RUN: begin
            if (!stable_d[i]) begin
              rpt_state_d[i] = RPT_IDLE;
              rpt_cnt_d[i]   = '0;
            end else if (rpt_cnt_q[i] ==
                         ((rpt_state_q[i] == RPT_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
              rpt_pulse[i]   = 1'b1;
              rpt_state_d[i] = RPT_RUN;
              rpt_cnt_d[i]   = '0;
            end else begin
              rpt_cnt_d[i]   = rpt_cnt_q[i] + CW'(1);
            end
          end
          default: begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
        rpt_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
    end
  end
`else
  // No repeat engine: the mask only names repeat-capable bits, so it gates nothing here
  assign rpt_pulse = RPT_MASK & {N_BTN{1'b0}};
`endif

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
